// File: rtl/data_mem_arb_pkg.sv
// Shared types and defaults for the two-port data memory arbiter.
package data_mem_arb_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // ARB: free arbitration; LOCKn: port n owns the memory for a burst.
  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational 2-way grant: round-robin priority when free, owner-first
// when locked, with a forced hand-over once the owner's burst is spent.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  input  logic       lock_act_i,
  input  logic       lock_owner_i,
  input  logic       force_rel_i,
  output logic [1:0] grant_o
);

  logic owner;
  logic other;

  assign owner = lock_owner_i;
  assign other = ~lock_owner_i;

  // Pick at most one port; grant is one-hot or zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_o = '0;
    if (lock_act_i) begin
      if (valid_i[owner] && !(force_rel_i && valid_i[other])) begin
        grant_o[owner] = 1'b1;
      end else if (valid_i[other]) begin
        grant_o[other] = 1'b1;
      end
    end else if (valid_i[0] && valid_i[1]) begin
      grant_o[prio_i] = 1'b1;
    end else begin
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbiter/sequencer between the core load/store port (0), the DMA loader
// port (1) and the 8-word data memory. One access per cycle, registered
// response one cycle after acceptance, bounded burst locking.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rq_valid_0,
  output logic              rq_ready_0,
  input  logic              rq_we_0,
  input  logic              rq_lock_0,
  input  logic [ADDR_W-1:0] rq_addr_0,
  input  logic [DATA_W-1:0] rq_wdata_0,
  output logic              rsp_valid_0,
  output logic [DATA_W-1:0] rsp_rdata_0,
  input  logic              rq_valid_1,
  output logic              rq_ready_1,
  input  logic              rq_we_1,
  input  logic              rq_lock_1,
  input  logic [ADDR_W-1:0] rq_addr_1,
  input  logic [DATA_W-1:0] rq_wdata_1,
  output logic              rsp_valid_1,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e              state_q, state_d;
  logic                    prio_q, prio_d;
  logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
  logic [NUM_PORTS-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata0_q, rsp_rdata0_d;
  logic [DATA_W-1:0]       rsp_rdata1_q, rsp_rdata1_d;

  logic [NUM_PORTS-1:0]    grant_raw;
  logic [NUM_PORTS-1:0]    grant;
  logic                    any_grant;
  logic                    sel;
  logic                    sel_we;
  logic                    sel_lock;
  logic                    force_rel;

  assign force_rel = (burst_cnt_q == CNT_W'(MAX_BURST));

  rr_arbiter2 u_arb (
    .valid_i      ({rq_valid_1, rq_valid_0}),
    .prio_i       (prio_q),
    .lock_act_i   (state_q != ARB),
    .lock_owner_i (state_q == LOCK1),
    .force_rel_i  (force_rel),
    .grant_o      (grant_raw)
  );

  // Nothing is granted during reset, so the memory sees no write that cycle.
  assign grant      = rst ? '0 : grant_raw;
  assign any_grant  = |grant;
  assign sel        = grant[1];
  assign sel_we     = sel ? rq_we_1   : rq_we_0;
  assign sel_lock   = sel ? rq_lock_1 : rq_lock_0;
  assign rq_ready_0 = grant[0];
  assign rq_ready_1 = grant[1];

  // Route the granted port to the memory; idle bus drives all zeros.
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    if (any_grant) begin
      mem_access_addr = sel ? rq_addr_1  : rq_addr_0;
      mem_write_data  = sel ? rq_wdata_1 : rq_wdata_0;
      mem_write_en    = sel_we;
      mem_read        = ~sel_we;
    end
  end

  // Next state, priority and burst count; any idle cycle drops the lock.
  always_comb begin
    state_d     = ARB;
    burst_cnt_d = '0;
    prio_d      = prio_q;
    if (any_grant) begin
      prio_d = ~sel;
      if (sel_lock) begin
        state_d = sel ? LOCK1 : LOCK0;
        if (state_q != state_d) begin
          burst_cnt_d = CNT_W'(1);
        end else if (force_rel) begin
          burst_cnt_d = burst_cnt_q;
        end else begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Capture the response of the access accepted this cycle.
  always_comb begin
    rsp_valid_d  = grant;
    rsp_rdata0_d = rsp_rdata0_q;
    rsp_rdata1_d = rsp_rdata1_q;
    if (grant[0]) rsp_rdata0_d = rq_we_0 ? '0 : mem_read_data;
    if (grant[1]) rsp_rdata1_d = rq_we_1 ? '0 : mem_read_data;
  end

  // State and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (rst) begin
      state_q      <= ARB;
      prio_q       <= 1'b0;
      burst_cnt_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata0_q <= '0;
      rsp_rdata1_q <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      burst_cnt_q  <= burst_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata0_q <= rsp_rdata0_d;
      rsp_rdata1_q <= rsp_rdata1_d;
    end
  end

  assign rsp_valid_0 = rsp_valid_q[0];
  assign rsp_valid_1 = rsp_valid_q[1];
  assign rsp_rdata_0 = rsp_rdata0_q;
  assign rsp_rdata_1 = rsp_rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 8-word memory,
// per-cycle grant/memory-bus checks and a queued response scoreboard.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rq_valid_0, rq_ready_0, rq_we_0, rq_lock_0;
  logic [15:0] rq_addr_0, rq_wdata_0;
  logic        rsp_valid_0;
  logic [15:0] rsp_rdata_0;
  logic        rq_valid_1, rq_ready_1, rq_we_1, rq_lock_1;
  logic [15:0] rq_addr_1, rq_wdata_1;
  logic        rsp_valid_1;
  logic [15:0] rsp_rdata_1;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read;

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .rq_valid_0(rq_valid_0), .rq_ready_0(rq_ready_0), .rq_we_0(rq_we_0),
    .rq_lock_0(rq_lock_0), .rq_addr_0(rq_addr_0), .rq_wdata_0(rq_wdata_0),
    .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
    .rq_valid_1(rq_valid_1), .rq_ready_1(rq_ready_1), .rq_we_1(rq_we_1),
    .rq_lock_1(rq_lock_1), .rq_addr_1(rq_addr_1), .rq_wdata_1(rq_wdata_1),
    .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  // Behavioural data memory: async read (0 when not reading), clocked write.
  logic [15:0] mem [8];
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    mem[3] = 16'h00A5;
  end
  assign mem_read_data = mem_read ? mem[mem_access_addr[2:0]] : 16'h0000;
  always @(posedge clk) if (mem_write_en) mem[mem_access_addr[2:0]] <= mem_write_data;

  typedef struct packed {
    logic        v;
    logic        we;
    logic        lk;
    logic [15:0] a;
    logic [15:0] d;
  } req_t;

  typedef struct {
    int          port;
    logic [15:0] rdata;
    int          due;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic mon_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t rd(input logic lk, input logic [15:0] a);
    return {1'b1, 1'b0, lk, a, 16'h0000};
  endfunction

  function automatic req_t wr(input logic lk, input logic [15:0] a, input logic [15:0] d);
    return {1'b1, 1'b1, lk, a, d};
  endfunction

  localparam req_t IDLE = '0;

  // One bus cycle: drive both ports, check grant and memory bus mid-cycle,
  // queue the expected response for the granted port (exp_g 2 = no grant).
  task automatic cycle(input string tag, input req_t r0, input req_t r1,
                       input int exp_g, input logic [15:0] exp_rd);
    req_t        g;
    logic [33:0] exp_mem;
    exp_t        e;
    rq_valid_0 = r0.v; rq_we_0 = r0.we; rq_lock_0 = r0.lk;
    rq_addr_0  = r0.a; rq_wdata_0 = r0.d;
    rq_valid_1 = r1.v; rq_we_1 = r1.we; rq_lock_1 = r1.lk;
    rq_addr_1  = r1.a; rq_wdata_1 = r1.d;
    @(negedge clk);
    check({tag, "/ready"}, {rq_ready_1, rq_ready_0},
          (exp_g == 0) ? 2'b01 : (exp_g == 1) ? 2'b10 : 2'b00);
    g       = (exp_g == 1) ? r1 : r0;
    exp_mem = (exp_g == 2) ? 34'h0 : {g.we, ~g.we, g.a, g.d};
    check({tag, "/mem_bus"}, {mem_write_en, mem_read, mem_access_addr, mem_write_data}, exp_mem);
    if (exp_g != 2) begin
      e.port  = exp_g;
      e.rdata = exp_rd;
      e.due   = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: whatever the DUT presents must match the queue head.
  logic [1:0] mon_ev;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_ev = 2'b00;
      if (q.size() > 0 && q[0].due == cyc) mon_ev[q[0].port] = 1'b1;
      if (mon_ev != 2'b00 || {rsp_valid_1, rsp_valid_0} !== 2'b00) begin
        check("rsp_valid", {rsp_valid_1, rsp_valid_0}, mon_ev);
        if (mon_ev != 2'b00) begin
          mon_e = q.pop_front();
          check("rsp_rdata", (mon_e.port == 1) ? rsp_rdata_1 : rsp_rdata_0, mon_e.rdata);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    cycle("reset", IDLE, IDLE, 2, 16'h0);
    mon_en = 1'b1;
    cycle("reset", IDLE, IDLE, 2, 16'h0);
    rst = 1'b0;
    check("reset/rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
    check("reset/rsp_rdata", {rsp_rdata_1, rsp_rdata_0}, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    do_reset();

    // Single read of word 3.
    cycle("single_rd", rd(0, 16'd3), IDLE, 0, 16'h00A5);

    // Port 1 write then read back.
    cycle("p1_wr", IDLE, wr(0, 16'd5, 16'h1234), 1, 16'h0000);
    cycle("p1_rd", IDLE, rd(0, 16'd5), 1, 16'h1234);

    // Contention after reset alternates starting with port 0.
    do_reset();
    for (int i = 0; i < 4; i++)
      cycle("contend", rd(0, 16'd3), rd(0, 16'd5), i % 2, (i % 2 == 0) ? 16'h00A5 : 16'h1234);

    // Make port 1 favoured, then a locked burst is cut after 4 grants.
    cycle("pre_burst", rd(0, 16'd2), IDLE, 0, 16'h1002);
    for (int i = 0; i < 4; i++)
      cycle("burst_p1", rd(0, 16'd3), rd(1, 16'd1), 1, 16'h1001);
    cycle("burst_release", rd(0, 16'd3), rd(1, 16'd1), 0, 16'h00A5);

    // Reset in the middle of a locked write burst.
    cycle("lock_wr", IDLE, wr(1, 16'd6, 16'hBEEF), 1, 16'h0000);
    rst = 1'b1;
    cycle("rst_mid_burst", rd(0, 16'd3), wr(1, 16'd7, 16'hCAFE), 2, 16'h0);
    rst = 1'b0;
    check("post_rst/rsp_valid", {rsp_valid_1, rsp_valid_0}, 2'b00);
    cycle("post_rst_arb", rd(0, 16'd3), rd(0, 16'd7), 0, 16'h00A5);
    cycle("no_write_in_rst", IDLE, rd(0, 16'd7), 1, 16'h1007);

    // Idle cycle drops a lock.
    cycle("lock_rd", IDLE, rd(1, 16'd6), 1, 16'hBEEF);
    cycle("idle", IDLE, IDLE, 2, 16'h0);
    cycle("after_idle", rd(0, 16'd3), rd(0, 16'd6), 0, 16'h00A5);
    cycle("after_idle_p1", IDLE, rd(0, 16'd6), 1, 16'hBEEF);
    cycle("drain", IDLE, IDLE, 2, 16'h0);
    cycle("drain", IDLE, IDLE, 2, 16'h0);

    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer for the 16-bit data memory (8 words, asynchronous read, write on rising clock edge, lower 3 address bits decoded). It sits between the memory and two masters:

- **Port 0:** the core's load/store stage.
- **Port 1:** the test/DMA loader.

It grants at most one access per cycle with round-robin fairness and optional bounded burst locking. Each accepted access gets a registered response one cycle later.

## Interface
- `ADDR_W`, 16, request/memory address width
- `DATA_W`, 16, data width
- `MAX_BURST`, 4, max consecutive locked grants to one port (≥1)

Ports (`n` = 0 or 1):
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `rq_valid_n`  in  1  request present on port n
- `rq_ready_n`  out  1  request on port n accepted this cycle
- `rq_we_n`  in  1  1 = write, 0 = read
- `rq_lock_n`  in  1  keep ownership for following requests
- `rq_addr_n`  in  ADDR_W  word address
- `rq_wdata_n`  in  DATA_W  write data
- `rsp_valid_n`  out  1  response for the access accepted last cycle
- `rsp_rdata_n`  out  DATA_W  read data; 0 for writes
- `mem_access_addr`  out  ADDR_W  to memory
- `mem_write_data`  out  DATA_W  to memory
- `mem_write_en`  out  1  to memory
- `mem_read`  out  1  to memory
- `mem_read_data`  in  DATA_W  from memory (0 when `mem_read` = 0)

## Operation

**FSM** (state held in a register, transitions on clock edge): `ARB`, `LOCK0`, `LOCK1`. Other registers:
- `prio`: 1 bit, the favoured port in `ARB`.
- `burst_cnt`: 0..`MAX_BURST`.

**Grant selection (combinational, same cycle):**
- **`ARB`:**
  - One valid port: grant it.
  - Both valid: grant `prio`.
- **`LOCKn`:**
  - Port n valid: grant n, unless `burst_cnt` = `MAX_BURST` and the other port is valid. In that case grant the other port (forced release).
  - Port n not valid: grant the other port if valid.

**Handshake:** `rq_ready_n` = grant to n. The access is accepted when `rq_valid_n` and `rq_ready_n` are both high.

**Memory drive:**
- Granted port's address and data drive `mem_access_addr` and `mem_write_data`.
- `mem_write_en` = granted `rq_we`; `mem_read` = granted ~`rq_we`.
- No grant: all memory outputs 0.

**Transitions on acceptance by port g:**
- `prio` ← ~g.
- If `rq_lock_g` = 1: next state `LOCKg`. `burst_cnt` ← `burst_cnt`+1 if already in `LOCKg`, else 1.
- If `rq_lock_g` = 0: next state `ARB`, `burst_cnt` ← 0.
- No acceptance: next state `ARB`, `burst_cnt` ← 0. Lock is dropped if the owner idles a cycle.

**Response:** at the accept edge, register `rsp_valid_g` ← 1 and `rsp_rdata_g` ← `mem_read_data` (reads) or 0 (writes). The other port's `rsp_valid` ← 0. `rsp_rdata` holds its value when there is no response.

**Address:** passed through unmodified. Aliasing above word 7 is the memory's behaviour and is not checked.

## Timing
- Reset values: state `ARB`, `prio` = 0, `burst_cnt` = 0, `rsp_valid_0`/`rsp_valid_1` = 0, `rsp_rdata_0`/`rsp_rdata_1` = 0.
- While `rst` is high: `rq_ready_0`/`rq_ready_1` = 0 and all memory outputs = 0, so no write occurs in the reset cycle.
- A reset arriving mid-burst aborts the lock. A response pending from the cycle before reset is cleared.
- Grant latency: 0 cycles (ready in the request cycle). Response latency: exactly 1 cycle after acceptance.
- Write data is committed at the accept edge. A read accepted in the next cycle returns the new value.
- Throughput: one access per cycle. Back-to-back accepts on one port give back-to-back `rsp_valid`.
- Worst-case wait of a valid port: `MAX_BURST` cycles.
- Requesters must hold `rq_*` stable while valid and not ready.

## Structure
- Package `data_mem_arb_pkg` holds:
  - state enum (`ARB`, `LOCK0`, `LOCK1`);
  - `NUM_PORTS` = 2;
  - default `ADDR_W`/`DATA_W`.
- Sub-module `rr_arbiter2`: combinational 2-way grant from `valid[1:0]`, `prio`, and lock owner/force-release inputs.
- Top level holds the FSM, counter, response registers and memory mux.

## Test plan
- **Single read:** reset, then port 0 reads addr 3 (memory word 3 = 0x00A5) → `rq_ready_0` same cycle; next cycle `rsp_valid_0` = 1, `rsp_rdata_0` = 0x00A5.
- **Write then read:** port 1 writes 0x1234 to addr 5, then reads addr 5 → write ack with rdata 0; read response 0x1234.
- **Contention:** both ports request unlocked reads continuously → grants alternate 0,1,0,1 starting with port 0 after reset.
- **Burst starvation bound:** port 1 locked with `MAX_BURST` = 4, port 0 valid throughout → port 1 granted 4 consecutive cycles, then port 0 granted.
- **Reset mid-burst:** `rst` asserted during a locked burst with a write pending → no `mem_write_en` in the reset cycle; after reset, state `ARB`, `prio` = 0, `rsp_valid` = 0.
- **Idle:** no valid requests → memory outputs all 0, no `rsp_valid`, lock released.
